ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Parametrised multi-cycle RV32M execute unit. It sits beside the ALU in the EX stage and uses the same valid/allow_in pipeline handshake as the stage registers. It accepts one multiply or divide per transaction and holds the result until MEM accepts it. It also supports a branch-cancel flush that kills the in-flight operation.

## Interface
Parameters:
- XLEN, 32: operand and result width (≥8, even).
- TAG_W, 5: width of the passthrough tag (the wb_reg index).
- FAST_MUL, 1: 1 = multiplies complete in one cycle using the `*` operator; 0 = multiplies iterate for XLEN cycles (shift-add).

Ports (clock domain clk; reset synchronous, active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  branch cancel; kills any held or in-flight op.
- in_valid  in  1  request valid from ID/EX.
- allow_in  out  1  unit can accept a request this cycle.
- in_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  destination register index, passed through unchanged.
- out_valid  out  1  result valid toward MEM.
- out_ready  in  1  mem_allow_in.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state is BUSY (drives EX hazard stall).

## Operation
- States: IDLE, BUSY, DONE. out_valid = (state==DONE); busy = (state==BUSY).
- allow_in = (state==IDLE) || (state==DONE && out_ready), and is forced to 0 while flush is high.
- Accept fires when in_valid && allow_in && !flush at a clock edge. On accept, latch op, operands and tag.
  - One-cycle ops go directly to DONE with out_result written: MUL* when FAST_MUL=1, divide by zero, signed overflow.
  - All other ops go to BUSY with the iteration counter at 0.
- BUSY: one iteration per edge. Restoring divide processes 1 quotient bit; shift-add multiply processes 1 multiplier bit. Both work on operand magnitudes.
  - The edge with counter==XLEN-1 applies the sign correction, writes out_result and moves to DONE.
- Sign rules:
  - MUL returns the low XLEN bits.
  - MULH treats both operands as signed and returns the high XLEN bits.
  - MULHSU treats a as signed, b as unsigned, and returns the high bits.
  - MULHU treats both as unsigned and returns the high bits.
  - DIV/REM truncate toward zero; the remainder takes the sign of the dividend.
- Special cases:
  - b==0: quotient = all ones; remainder = a (both signed and unsigned forms).
  - DIV/REM with a==MIN_INT and b==-1: quotient = MIN_INT; remainder = 0.
- DONE: out_result and out_tag stay stable while out_ready=0.
  - On out_ready=1, go to IDLE, or go to DONE/BUSY immediately if a new accept fires on the same edge (back-to-back).
- flush has priority over everything except rst. It forces IDLE at the next edge, discards the held result and accepts nothing that cycle.
- rst forces IDLE, out_result=0, out_tag=0 and counter=0. All outputs read 0 after reset except allow_in=1.

## Timing
- Accept at edge N.
  - One-cycle ops: out_valid=1 from N+1.
  - Iterative ops: busy=1 from N+1 through N+XLEN; out_valid=1 from N+XLEN+1. That is XLEN edges of BUSY, so out_valid rises 1+XLEN cycles after accept.
- With out_ready held at 1, back-to-back one-cycle ops sustain one result per cycle.
- out_valid drops the cycle after the out_ready handshake edge unless a new one-cycle op was accepted on that edge.
- flush at edge M: out_valid=0 and busy=0 from M+1; allow_in=1 from M+1.
- rst mid-BUSY at edge M: the same outputs as flush from M+1; counter=0.
- The counter is a log2(XLEN)+1 bit unsigned value. It never wraps, because the BUSY exit is at XLEN-1.

## Test plan
- DIV: a=-7 (0xFFFFFFF9), b=2 -> out_result=0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. Both appear exactly 33 cycles after accept with busy high for 32 cycles (XLEN=32).
- MULHU: 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH: 0x80000000×2 -> 0xFFFFFFFF. MUL: 3×-5 -> 0xFFFFFFF1. Run the FAST_MUL=1 build and check 1-cycle latency; run the FAST_MUL=0 build and check 33-cycle latency.
- Special cases:
  - DIVU x/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0.
  - Each case takes 1-cycle latency and busy never asserts.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_result and out_tag stay stable and allow_in=0. Then raise out_ready with in_valid and a new op -> the handover occurs on the same edge and the next result carries the new tag.
- Flush at BUSY iteration 10 of a DIV -> IDLE the next cycle and no out_valid pulse. A new DIV accepted afterwards returns a correct result.
- Assert rst at iteration 5 of an iterative MUL -> all outputs reset values from the next cycle and allow_in=1. Raise flush and in_valid together -> no accept occurs.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execute unit: one op per valid/allow_in transaction,
// single-cycle fast paths plus a shared shift-add / restoring-divide datapath.
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int FAST_MUL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             allow_in,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;

    logic                accept;
    logic                a_signed, b_signed, a_neg, b_neg, in_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [2*XLEN-1:0]   a_ext, b_ext, fast_prod;
    logic                one_cycle;
    logic [XLEN-1:0]     quick_result;

    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign allow_in  = !flush && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && allow_in;

    // Decode of the incoming request: operand magnitudes, result sign and
    // the ops that finish in a single cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        one_cycle    = 1'b0;
        quick_result = '0;
        a_signed  = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
        b_signed  = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
        a_neg     = a_signed && in_a[XLEN-1];
        b_neg     = b_signed && in_b[XLEN-1];
        a_mag     = a_neg ? -in_a : in_a;
        b_mag     = b_neg ? -in_b : in_b;
        in_neg    = (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);
        a_ext     = a_signed ? {{XLEN{in_a[XLEN-1]}}, in_a} : {{XLEN{1'b0}}, in_a};
        b_ext     = b_signed ? {{XLEN{in_b[XLEN-1]}}, in_b} : {{XLEN{1'b0}}, in_b};
        fast_prod = a_ext * b_ext;
        if (in_op[2]) begin
            if (in_b == '0) begin
                one_cycle    = 1'b1;
                quick_result = in_op[1] ? in_a : '1;
            end else if (!in_op[0] && in_a == MIN_INT && in_b == '1) begin
                one_cycle    = 1'b1;
                quick_result = in_op[1] ? '0 : MIN_INT;
            end
        end else if (FAST_MUL != 0) begin
            one_cycle    = 1'b1;
            quick_result = (in_op[1:0] == 2'd0) ? fast_prod[XLEN-1:0]
                                                : fast_prod[2*XLEN-1:XLEN];
        end
    end

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, div_next, prod_c;
    logic [XLEN:0]       rem_sh;
    logic                div_ge;
    logic [XLEN-1:0]     rem_sub, div_sel, div_res, mul_res, final_result;

    // One iteration: acc_q holds {partial product, multiplier} for multiply
    // and {partial remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = (rem_sh >= {1'b0, opnd_q});
        rem_sub  = rem_sh[XLEN-1:0] - opnd_q;
        div_next = div_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                          : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        prod_c   = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q[1:0] == 2'd0) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
        div_sel  = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res  = neg_q ? -div_sel : div_sel;
        final_result = op_q[2] ? div_res : mul_res;
    end

    // NOTE: only control state and visible outputs are reset; the operand and
    // accumulator registers are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                BUSY: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        out_result <= final_result;
                        state      <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        op_q    <= in_op;
                        neg_q   <= in_neg;
                        out_tag <= in_tag;
                        opnd_q  <= in_op[2] ? b_mag : a_mag;
                        acc_q   <= {{XLEN{1'b0}}, (in_op[2] ? a_mag : b_mag)};
                        cnt     <= '0;
                        if (one_cycle) begin
                            out_result <= quick_result;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: instance 0 uses the fast multiplier,
// instance 1 the iterative one; a negedge monitor pops expected results.
module tb_ex_muldiv_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11, flush = 2'b00, in_valid = 2'b00, out_ready = 2'b11;
    logic [2:0]  in_op [2];
    logic [31:0] in_a [2];
    logic [31:0] in_b [2];
    logic [4:0]  in_tag [2];
    wire  [1:0]  allow_in, out_valid, busy;
    wire  [31:0] out_result [2];
    wire  [4:0]  out_tag [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .TAG_W(5), .FAST_MUL(1)) dut_fast (
        .clk(clk), .rst(rst[0]), .flush(flush[0]), .in_valid(in_valid[0]),
        .allow_in(allow_in[0]), .in_op(in_op[0]), .in_a(in_a[0]), .in_b(in_b[0]),
        .in_tag(in_tag[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_result(out_result[0]), .out_tag(out_tag[0]), .busy(busy[0])
    );

    ex_muldiv_unit #(.XLEN(32), .TAG_W(5), .FAST_MUL(0)) dut_slow (
        .clk(clk), .rst(rst[1]), .flush(flush[1]), .in_valid(in_valid[1]),
        .allow_in(allow_in[1]), .in_op(in_op[1]), .in_a(in_a[1]), .in_b(in_b[1]),
        .in_tag(in_tag[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_result(out_result[1]), .out_tag(out_tag[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (out_valid[d] && out_ready[d]) begin
                exp_t e;
                logic got;
                got = 1'b0;
                if (d == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    got = 1'b1;
                end else if (d == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    got = 1'b1;
                end
                if (!got) begin
                    check($sformatf("unexpected_result_dut%0d", d), 32'(out_valid[d]), 32'd0);
                end else begin
                    check($sformatf("result_dut%0d_tag%0d", d, e.tag), out_result[d], e.res);
                    check($sformatf("tag_dut%0d_tag%0d", d, e.tag), 32'(out_tag[d]), 32'(e.tag));
                end
            end
        end
    end

    task automatic push(input int d, input logic [31:0] res, input logic [4:0] tag);
        exp_t e;
        e.res = res;
        e.tag = tag;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input int d, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_a[d]     = a;
        in_b[d]     = b;
        in_tag[d]   = tag;
    endtask

    // Issue one op with out_ready high, then measure latency and busy cycles.
    task automatic send(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp, input int exp_lat, input string name);
        logic ok;
        int   lat, bcnt;
        ok = 1'b0;
        drive(d, op, a, b, tag);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (allow_in[d]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check({name, "_accept_timeout"}, 32'(allow_in[d]), 32'd1);
            in_valid[d] = 1'b0;
            return;
        end
        push(d, exp, tag);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid[d]) begin
                lat = k;
                break;
            end
            if (busy[d]) bcnt++;
            @(posedge clk); #1;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input int d, input string name);
        check({name, "_out_valid"}, 32'(out_valid[d]), 32'd0);
        check({name, "_busy"}, 32'(busy[d]), 32'd0);
        check({name, "_allow_in"}, 32'(allow_in[d]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic saw;
        for (int d = 0; d < 2; d++) begin
            in_op[d] = '0; in_a[d] = '0; in_b[d] = '0; in_tag[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 2'b00;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d, $sformatf("reset_dut%0d", d));
            check($sformatf("reset_result_dut%0d", d), out_result[d], 32'd0);
            check($sformatf("reset_tag_dut%0d", d), 32'(out_tag[d]), 32'd0);
        end
        @(posedge clk); #1;

        // Iterative divide paths and their 33-cycle latency.
        send(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33, "div_m7_2");
        send(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        send(0, 3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 33, "divu_100_7");
        send(0, 3'd7, 32'd100, 32'd7, 5'd4, 32'd2, 33, "remu_100_7");

        // Fast multiplies.
        send(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 1, "f_mulhu");
        send(0, 3'd1, 32'h8000_0000, 32'd2, 5'd6, 32'hFFFF_FFFF, 1, "f_mulh");
        send(0, 3'd0, 32'd3, 32'hFFFF_FFFB, 5'd7, 32'hFFFF_FFF1, 1, "f_mul");
        send(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, "f_mulhsu");

        // Divide special cases finish in one cycle.
        send(0, 3'd5, 32'hDEAD_BEEF, 32'd0, 5'd11, 32'hFFFF_FFFF, 1, "divu_by0");
        send(0, 3'd6, 32'h0000_1234, 32'd0, 5'd12, 32'h0000_1234, 1, "rem_by0");
        send(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1, "div_ovf");
        send(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1, "rem_ovf");

        // Iterative multiplies.
        send(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 33, "s_mulhu");
        send(1, 3'd1, 32'h8000_0000, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, "s_mulh");
        send(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 33, "s_mulhsu");
        send(1, 3'd0, 32'd3, 32'hFFFF_FFFB, 5'd7, 32'hFFFF_FFF1, 33, "s_mul");

        // Back-to-back one-cycle ops with out_ready held high.
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin drive(0, 3'd0, 32'd2, 32'd3, 5'd21); push(0, 32'd6, 5'd21); end
                1: begin drive(0, 3'd0, 32'd4, 32'd4, 5'd22); push(0, 32'd16, 5'd22); end
                default: begin drive(0, 3'd3, 32'h8000_0000, 32'd4, 5'd23); push(0, 32'd2, 5'd23); end
            endcase
            @(negedge clk);
            check($sformatf("b2b_allow_in_%0d", i), 32'(allow_in[0]), 32'd1);
            if (i > 0) check($sformatf("b2b_out_valid_%0d", i), 32'(out_valid[0]), 32'd1);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", 32'(out_valid[0]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_valid_drops", 32'(out_valid[0]), 32'd0);
        @(posedge clk); #1;

        // Backpressure: result held stable while out_ready is low.
        out_ready[0] = 1'b0;
        drive(0, 3'd0, 32'd7, 32'd6, 5'd9);
        push(0, 32'd42, 5'd9);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", i), 32'(out_valid[0]), 32'd1);
            check($sformatf("bp_result_%0d", i), out_result[0], 32'd42);
            check($sformatf("bp_tag_%0d", i), 32'(out_tag[0]), 32'd9);
            check($sformatf("bp_allow_in_%0d", i), 32'(allow_in[0]), 32'd0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        drive(0, 3'd0, 32'd5, 32'd5, 5'd10);
        push(0, 32'd25, 5'd10);
        @(negedge clk);
        check("bp_handover_allow_in", 32'(allow_in[0]), 32'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("bp_new_valid", 32'(out_valid[0]), 32'd1);
        check("bp_new_tag", 32'(out_tag[0]), 32'd10);
        @(posedge clk); #1;

        // Flush a divide at iteration 10; nothing may come out of it.
        drive(0, 3'd4, 32'd100, 32'hFFFF_FFF9, 5'd15);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "flush");
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw = saw | out_valid[0];
        end
        check("flush_no_pulse", 32'(saw), 32'd0);
        @(posedge clk); #1;
        send(0, 3'd4, 32'd100, 32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFF2, 33, "div_after_flush");
        send(0, 3'd6, 32'd100, 32'hFFFF_FFF9, 5'd17, 32'd2, 33, "rem_after_flush");

        // Reset during an iterative multiply, then flush blocks an accept.
        drive(1, 3'd0, 32'd3, 32'hFFFF_FFFB, 5'd18);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check_idle_outputs(1, "rst_mid");
        check("rst_mid_result", out_result[1], 32'd0);
        check("rst_mid_tag", 32'(out_tag[1]), 32'd0);
        @(posedge clk); #1;
        flush[1] = 1'b1;
        drive(1, 3'd0, 32'd2, 32'd2, 5'd19);
        @(negedge clk);
        check("flush_blocks_allow_in", 32'(allow_in[1]), 32'd0);
        @(posedge clk); #1;
        flush[1]    = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        check_idle_outputs(1, "flush_no_accept");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard0_drained", 32'(q0.size()), 32'd0);
        check("scoreboard1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
